if_stage: RTL
=============

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter PC_STEP, default 4, sequential PC increment; IM is indexed by byte address, so instructions sit at multiples of 4.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port stall  input  1  hold PC and IF/ID register.
REQ-006 SHALL have port flush  input  1  squash the instruction entering IF/ID.
REQ-007 SHALL have port branch_taken  input  1  redirect PC to branch_target.
REQ-008 SHALL have port branch_target  input  32  absolute branch address.
REQ-009 SHALL have port jump  input  1  redirect PC to the jump target.
REQ-010 SHALL have port jump_index  input  26  J-type index field.
REQ-011 SHALL have port instruction  input  32  IM read data for the current address.
REQ-012 SHALL have port address  output  32  fetch address to IM, equal to the PC register.
REQ-013 SHALL have port if_id_instr  output  32  registered instruction.
REQ-014 SHALL have port if_id_pc4  output  32  registered PC+PC_STEP of that instruction.
REQ-015 SHALL have port if_id_valid  output  1  IF/ID holds a real instruction.
REQ-016 SHALL have port fetch_count  output  32  count of valid instructions written into IF/ID.

Function
REQ-017 SHALL drive address combinationally from the PC register, with zero latency to IM.
REQ-018 SHALL compute pc4 = pc + PC_STEP modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
REQ-019 SHALL compute the jump target as {pc4[31:28], jump_index, 2'b00}.
REQ-020 SHALL force bits [1:0] of branch_target to 00 before loading it into the PC.
REQ-021 SHALL select the next PC by priority: rst > branch_taken > jump > stall (hold) > pc4.
REQ-022 SHALL apply a redirect (branch_taken or jump) even when stall is high.
REQ-023 SHALL load IF/ID with {instruction, pc4, valid=1} each edge when no other condition below applies.
REQ-024 SHALL write if_id_valid=0 and if_id_instr=0 when flush, branch_taken or jump is high, including when stall is high; if_id_pc4 is don't-care in that case.
REQ-025 SHALL hold all IF/ID outputs unchanged when stall is high and no squash condition is active.
REQ-026 SHALL increment fetch_count by 1 on an edge only when IF/ID is written with valid=1, wrapping at 2^32.
REQ-027 SHALL give one cycle of redirect penalty: the target address appears on address the cycle after the redirect is sampled, and its instruction reaches IF/ID one edge later.

Reset
REQ-028 SHALL, on an edge with rst high, set pc=RESET_PC, if_id_instr=0, if_id_pc4=0, if_id_valid=0 and fetch_count=0, overriding every other input.
REQ-029 SHALL ignore an in-flight redirect or stall on a mid-operation reset; the first fetch after rst falls is from RESET_PC.

Verification
REQ-030 SHALL cover reset: hold rst high 2 cycles, release -> address=0, if_id_valid=0, fetch_count=0; after next edge if_id_pc4=4, valid=1.
REQ-031 SHALL cover free-run: IM returns word at 4/8/12 -> address sequence 0,4,8,12,16; if_id_pc4 sequence 4,8,12,16; fetch_count=4 after 4 edges.
REQ-032 SHALL cover stall: pc=8, stall high 3 cycles -> address stays 8, IF/ID unchanged, fetch_count unchanged; release -> address 12.
REQ-033 SHALL cover branch: pc=12, branch_taken=1, branch_target=32'h43 -> next address 32'h40, if_id_valid=0, then IF/ID gets pc4=32'h44.
REQ-034 SHALL cover jump: pc=8, jump=1, jump_index=26'h10 -> next address 32'h40; jump and branch_taken (target 32'h80) together -> 32'h80.
REQ-035 SHALL cover simultaneous events and mid-run reset: stall and flush together -> PC held, if_id_valid=0; rst during a branch -> address=0, fetch_count=0.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection and the IF/ID pipeline register.
// Redirects (branch/jump) cost one bubble; stall freezes PC and IF/ID unless a squash is pending.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic [31:0] instruction,
  output logic [31:0] address,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [31:0] fetch_count
);

  logic [31:0] pc_reg, pc_next;
  logic [31:0] pc4;
  logic [31:0] jump_target;
  logic        squash;

  logic [31:0] if_id_instr_reg, if_id_instr_next;
  logic [31:0] if_id_pc4_reg, if_id_pc4_next;
  logic        if_id_valid_reg, if_id_valid_next;
  logic [31:0] fetch_count_reg, fetch_count_next;

  assign pc4         = pc_reg + PC_STEP;
  assign jump_target = {pc4[31:28], jump_index, 2'b00};
  // Anything that redirects or flushes the front end kills the word fetched this cycle.
  assign squash      = flush | branch_taken | jump;

  always_comb begin
    pc_next = pc4;
    if (branch_taken)
      pc_next = {branch_target[31:2], 2'b00};
    else if (jump)
      pc_next = jump_target;
    else if (stall)
      pc_next = pc_reg;
  end

  always_comb begin
    if_id_instr_next = if_id_instr_reg;
    if_id_pc4_next   = if_id_pc4_reg;
    if_id_valid_next = if_id_valid_reg;
    fetch_count_next = fetch_count_reg;
    if (squash) begin
      // pc4 of a bubble is never consumed, so it is simply left as is.
      if_id_instr_next = 32'h0;
      if_id_valid_next = 1'b0;
    end else if (!stall) begin
      if_id_instr_next = instruction;
      if_id_pc4_next   = pc4;
      if_id_valid_next = 1'b1;
      fetch_count_next = fetch_count_reg + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg          <= RESET_PC;
      if_id_instr_reg <= 32'h0;
      if_id_pc4_reg   <= 32'h0;
      if_id_valid_reg <= 1'b0;
      fetch_count_reg <= 32'h0;
    end else begin
      pc_reg          <= pc_next;
      if_id_instr_reg <= if_id_instr_next;
      if_id_pc4_reg   <= if_id_pc4_next;
      if_id_valid_reg <= if_id_valid_next;
      fetch_count_reg <= fetch_count_next;
    end
  end

  assign address     = pc_reg;
  assign if_id_instr = if_id_instr_reg;
  assign if_id_pc4   = if_id_pc4_reg;
  assign if_id_valid = if_id_valid_reg;
  assign fetch_count = fetch_count_reg;

endmodule
